// File: rtl/alu_op_sequencer_if.sv
// Handshake and ALU-side bus for the relay ALU op sequencer.
// slave = sequencer side, master = instruction source / ALU side.
interface alu_op_sequencer_if;
  logic [7:0] instr;
  logic       instr_valid;
  logic       instr_ready;
  logic [2:0] fctn_code;
  logic       alu_en;
  logic [7:0] alu_result;
  logic       alu_carry;
  logic       ld_a;
  logic       ld_d;
  logic [7:0] result_q;
  logic       cc_zero;
  logic       cc_carry;
  logic       cc_sign;
  logic       done;
  logic       illegal;

  modport slave (
    input  instr, instr_valid,
    input  alu_result, alu_carry,
    output instr_ready, fctn_code, alu_en,
    output ld_a, ld_d, result_q,
    output cc_zero, cc_carry, cc_sign,
    output done, illegal
  );

  modport master (
    output instr, instr_valid,
    output alu_result, alu_carry,
    input  instr_ready, fctn_code, alu_en,
    input  ld_a, ld_d, result_q,
    input  cc_zero, cc_carry, cc_sign,
    input  done, illegal
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Multi-cycle relay ALU controller: drive, settle, latch into A or D.
// Define ALU_SEQ_CC_EN to build the condition-code flags.
module alu_op_sequencer #(
  parameter int SETTLE_CYCLES = 2
) (
  input logic clk,
  input logic reset,
  alu_op_sequencer_if.slave bus
);
  localparam int CW = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE, DRIVE, LATCH, ERR
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          dest;
  logic [2:0]    fctn;
  logic [7:0]    result;
  logic          accept, legal;

  logic       ready, alu_en, ld_a, ld_d;
  logic       done, illegal;
  logic [2:0] fctn_code;

  assign accept = bus.instr_valid
               && (state == IDLE);
  assign legal = (bus.instr[7:4] == 4'b1000)
              && (bus.instr[2:0] != 3'b111);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      dest   <= 1'b0;
      fctn   <= 3'b000;
      result <= 8'h00;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (accept) begin
        dest <= bus.instr[3];
        fctn <= bus.instr[2:0];
      end
      if (state == LATCH)
        result <= bus.alu_result;
    end
  end

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    ready     = 1'b0;
    alu_en    = 1'b0;
    fctn_code = 3'b000;
    ld_a      = 1'b0;
    ld_d      = 1'b0;
    done      = 1'b0;
    illegal   = 1'b0;
    unique case (state)
      IDLE: begin
        ready = 1'b1;
        if (bus.instr_valid) begin
          if (legal) begin
            state_nx = DRIVE;
            cnt_nx   = CW'(SETTLE_CYCLES);
          end else begin
            state_nx = ERR;
          end
        end
      end
      DRIVE: begin
        alu_en    = 1'b1;
        fctn_code = fctn;
        cnt_nx    = cnt - CW'(1);
        if (cnt == CW'(1))
          state_nx = LATCH;
      end
      LATCH: begin
        alu_en    = 1'b1;
        fctn_code = fctn;
        ld_a      = ~dest;
        ld_d      = dest;
        done      = 1'b1;
        state_nx  = IDLE;
      end
      ERR: begin
        illegal  = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.instr_ready = ready;
  assign bus.alu_en      = alu_en;
  assign bus.fctn_code   = fctn_code;
  assign bus.ld_a        = ld_a;
  assign bus.ld_d        = ld_d;
  assign bus.done        = done;
  assign bus.illegal     = illegal;
  assign bus.result_q    = result;

`ifdef ALU_SEQ_CC_EN
  logic zf, cf, sf;

  // Only ADD/INC produce a meaningful carry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      zf <= 1'b0;
      cf <= 1'b0;
      sf <= 1'b0;
    end else if (state == LATCH) begin
      zf <= (bus.alu_result == 8'h00);
      sf <= bus.alu_result[7];
      cf <= bus.alu_carry
         && (fctn[2:1] == 2'b00);
    end
  end

  assign bus.cc_zero  = zf;
  assign bus.cc_carry = cf;
  assign bus.cc_sign  = sf;
`else
  assign bus.cc_zero  = 1'b0;
  assign bus.cc_carry = 1'b0;
  assign bus.cc_sign  = 1'b0;
`endif
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: random and directed ops
// against a queue-based reference model.
module tb_alu_op_sequencer;
  localparam int S = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_op_sequencer_if bus();

  alu_op_sequencer #(.SETTLE_CYCLES(S)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    bit         legal;
    bit         dest;
    logic [2:0] fctn;
    logic [7:0] res;
    bit         z, c, s;
    int         cyc;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  bit   pend = 0;

  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;

  int         busy = 0;
  bit         op_legal = 0;
  logic [2:0] op_fctn = 3'b000;
  logic [7:0] m_res = 8'h00;
  bit         m_z = 0, m_c = 0, m_s = 0;

  logic [7:0] d_ins[7] = '{8'h80, 8'h89, 8'h8A, 8'h87, 8'h40, 8'h85, 8'h81};
  logic [7:0] d_res[7] = '{8'hFF, 8'h00, 8'h3C, 8'h11, 8'h22, 8'h80, 8'h7F};
  bit         d_cy[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Called at a falling edge; drives the next rising edge.
  task automatic step(input bit v, input logic [7:0] ins,
                      input logic [7:0] res, input bit cy, output bit acc);
    exp_t e;
    bit   lg;
    acc = 0;
    if (busy > 0) busy--;
    chk("instr_ready", bus.instr_ready, busy == 0);
    chk("alu_en", bus.alu_en, (busy > 0) && op_legal);
    chk("fctn_code", bus.fctn_code, ((busy > 0) && op_legal) ? op_fctn : 3'b000);
    bus.instr_valid = v;
    bus.instr = ins;
    if (busy == 0) begin
      bus.alu_result = res;
      bus.alu_carry  = cy;
    end
    if (v && busy == 0) begin
      acc = 1;
      lg = (ins[7:4] == 4'h8) && (ins[2:0] != 3'b111);
      op_legal = lg;
      op_fctn = ins[2:0];
      e.legal = lg;
      e.dest = ins[3];
      e.fctn = ins[2:0];
      if (lg) begin
        m_res = res;
`ifdef ALU_SEQ_CC_EN
        m_z = (res == 8'h00);
        m_s = res[7];
        m_c = cy && (ins[2:0] <= 3'd1);
`endif
        e.cyc = cyc + S + 1;
        busy = S + 2;
      end else begin
        e.cyc = cyc + 1;
        busy = 2;
      end
      e.res = m_res;
      e.z = m_z;
      e.c = m_c;
      e.s = m_s;
      q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic rand_step();
    bit         acc;
    logic [7:0] ins;
    ins = ($urandom_range(0, 3) == 0) ? 8'($urandom) : {4'h8, 4'($urandom)};
    step($urandom_range(0, 3) != 0, ins, 8'($urandom_range(0, 5) == 0 ? 0 : $urandom),
         1'($urandom), acc);
  endtask

  task automatic idle_steps(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(0, 8'h00, 8'h00, 0, acc);
  endtask

  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (pend) begin
        chk("result_q", bus.result_q, cur.res);
        chk("cc_zero", bus.cc_zero, cur.z);
        chk("cc_carry", bus.cc_carry, cur.c);
        chk("cc_sign", bus.cc_sign, cur.s);
        pend = 0;
      end
      if (bus.done === 1'b1 || bus.illegal === 1'b1) begin
        if (q.size() == 0) begin
          chk("unexpected_done_illegal", {bus.done, bus.illegal}, 2'b00);
        end else begin
          cur = q.pop_front();
          chk("done", bus.done, cur.legal);
          chk("illegal", bus.illegal, !cur.legal);
          chk("latency_cycle", cyc, cur.cyc);
          chk("ld_a", bus.ld_a, cur.legal && !cur.dest);
          chk("ld_d", bus.ld_d, cur.legal && cur.dest);
          pend = 1;
        end
      end else begin
        chk("strobe_outside_latch", {bus.ld_a, bus.ld_d}, 2'b00);
      end
    end
  end

  initial begin
    bit acc;
    reset = 1'b1;
    bus.instr_valid = 1'b0;
    bus.instr = 8'h00;
    bus.alu_result = 8'h00;
    bus.alu_carry = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", bus.instr_ready, 1'b1);
    chk("rst_alu_en", bus.alu_en, 1'b0);
    chk("rst_fctn", bus.fctn_code, 3'b000);
    chk("rst_strobes", {bus.ld_a, bus.ld_d, bus.done, bus.illegal}, 4'b0000);
    chk("rst_result", bus.result_q, 8'h00);
    chk("rst_cc", {bus.cc_zero, bus.cc_carry, bus.cc_sign}, 3'b000);
    reset = 1'b0;
    @(negedge clk);

    // Directed ops with instr_valid held high throughout.
    for (int i = 0; i < 7; i++) begin
      acc = 0;
      while (!acc) step(1, d_ins[i], d_res[i], d_cy[i], acc);
    end
    for (int i = 0; i < 300; i++) rand_step();
    idle_steps(S + 3);

    // Reset in the middle of the settle window.
    bus.instr_valid = 1'b1;
    bus.instr = 8'h81;
    bus.alu_result = 8'h55;
    @(posedge clk);
    #1 bus.instr_valid = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk("midrst_alu_en", bus.alu_en, 1'b0);
    chk("midrst_ready", bus.instr_ready, 1'b1);
    chk("midrst_fctn", bus.fctn_code, 3'b000);
    chk("midrst_result", bus.result_q, 8'h00);
    chk("midrst_cc", {bus.cc_zero, bus.cc_carry, bus.cc_sign}, 3'b000);
    @(negedge clk);
    reset = 1'b0;
    busy = 0;
    op_legal = 0;
    m_res = 8'h00;
    m_z = 0;
    m_c = 0;
    m_s = 0;
    idle_steps(S + 3);

    for (int i = 0; i < 60; i++) rand_step();
    idle_steps(S + 4);
    chk("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
